// File: rtl/xfer_page_queue.sv
// Paged host/device transfer queue: an RX ring (host writes, device reads) and a TX ring
// (device writes, host reads). Pages become visible only when complete and are freed only when fully read.

module xfer_page_ring #(
    parameter int DATA_WIDTH = 32,
    parameter int PAGE_WORDS = 1024,
    parameter int NUM_PAGES  = 4
) (
    input  logic                  clock_host,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [7:0]            full_pages,
    output logic                  wr_drop,
    output logic                  rd_drop
);
    localparam int PW = $clog2(NUM_PAGES);
    localparam int IW = $clog2(PAGE_WORDS);
    localparam logic [PW-1:0] PAGE_LAST = PW'(NUM_PAGES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(PAGE_WORDS - 1);
    localparam logic [7:0]    PAGE_CAP  = 8'(NUM_PAGES);

    logic [DATA_WIDTH-1:0] mem [NUM_PAGES*PAGE_WORDS];
    logic [PW-1:0] head, tail;
    logic [IW-1:0] head_idx, tail_idx;
    logic wr_ok, rd_ok, commit, freed;

    assign wr_ok   = wr_req && (full_pages < PAGE_CAP);
    assign rd_ok   = rd_req && (full_pages != 8'd0);
    assign commit  = wr_ok && (head_idx == IDX_LAST);
    assign freed   = rd_ok && (tail_idx == IDX_LAST);
    assign wr_drop = wr_req && !wr_ok;
    assign rd_drop = rd_req && !rd_ok;

    // Storage is not cleared on reset; the pointers alone define what is valid.
    always_ff @(posedge clock_host) begin
        if (wr_ok && !reset)
            mem[{head, head_idx}] <= wr_data;
    end

    always_ff @(posedge clock_host) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            head_idx   <= '0;
            tail_idx   <= '0;
            full_pages <= 8'd0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_valid <= rd_ok;
            if (wr_ok) begin
                head_idx <= head_idx + 1'b1;
                if (commit)
                    head <= (head == PAGE_LAST) ? '0 : head + 1'b1;
            end
            if (rd_ok) begin
                rd_data  <= mem[{tail, tail_idx}];
                tail_idx <= tail_idx + 1'b1;
                if (freed)
                    tail <= (tail == PAGE_LAST) ? '0 : tail + 1'b1;
            end
            if (commit && !freed)
                full_pages <= full_pages + 8'd1;
            else if (freed && !commit)
                full_pages <= full_pages - 8'd1;
        end
    end
endmodule

module xfer_page_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int PAGE_WORDS = 1024,
    parameter int NUM_PAGES  = 4
) (
    input  logic                  clock_host,
    input  logic                  reset,
    input  logic                  host_select,
    input  logic                  hwrite_enable,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    input  logic                  dev_rx_rd_en,
    output logic [DATA_WIDTH-1:0] dev_rx_rdata,
    output logic                  dev_rx_rvalid,
    input  logic                  dev_tx_wr_en,
    input  logic [DATA_WIDTH-1:0] dev_tx_wdata,
    input  logic                  gs_select,
    input  logic                  gs_write_enable,
    output logic [7:0]            gs_out,
    output logic                  gs_out_enable,
    output logic [7:0]            rx_full_pages,
    output logic [7:0]            tx_full_pages,
    output logic                  err_overflow,
    output logic                  err_underflow
);
    localparam logic [7:0] PAGE_CAP = 8'(NUM_PAGES);

    logic rx_wr_drop, rx_rd_drop, tx_wr_drop, tx_rd_drop;

    xfer_page_ring #(.DATA_WIDTH(DATA_WIDTH), .PAGE_WORDS(PAGE_WORDS), .NUM_PAGES(NUM_PAGES)) u_rx (
        .clock_host (clock_host),
        .reset      (reset),
        .wr_req     (host_select && hwrite_enable),
        .wr_data    (host_wdata),
        .rd_req     (dev_rx_rd_en),
        .rd_data    (dev_rx_rdata),
        .rd_valid   (dev_rx_rvalid),
        .full_pages (rx_full_pages),
        .wr_drop    (rx_wr_drop),
        .rd_drop    (rx_rd_drop)
    );

    xfer_page_ring #(.DATA_WIDTH(DATA_WIDTH), .PAGE_WORDS(PAGE_WORDS), .NUM_PAGES(NUM_PAGES)) u_tx (
        .clock_host (clock_host),
        .reset      (reset),
        .wr_req     (dev_tx_wr_en),
        .wr_data    (dev_tx_wdata),
        .rd_req     (host_select && !hwrite_enable),
        .rd_data    (host_rdata),
        .rd_valid   (host_rvalid),
        .full_pages (tx_full_pages),
        .wr_drop    (tx_wr_drop),
        .rd_drop    (tx_rd_drop)
    );

    // Status reflects the counts as they stood before this edge's updates.
    always_ff @(posedge clock_host) begin
        if (reset) begin
            gs_out        <= 8'd0;
            gs_out_enable <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            gs_out_enable <= gs_select;
            if (gs_select)
                gs_out <= gs_write_enable ? (PAGE_CAP - rx_full_pages) : tx_full_pages;
            err_overflow  <= err_overflow  || rx_wr_drop || tx_wr_drop;
            err_underflow <= err_underflow || rx_rd_drop || tx_rd_drop;
        end
    end
endmodule

// File: tb/tb_xfer_page_queue.sv
// Lockstep bench for xfer_page_queue with 4-word pages and a 3-page ring per direction;
// a reference model predicts counts and flags, and per-direction queues hold the expected read data.

module tb_xfer_page_queue;
    localparam int DW = 32;
    localparam int PWORDS = 4;
    localparam int NPAGES = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          host_select = 1'b0, hwrite_enable = 1'b0;
    logic [DW-1:0] host_wdata = '0;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          dev_rx_rd_en = 1'b0;
    logic [DW-1:0] dev_rx_rdata;
    logic          dev_rx_rvalid;
    logic          dev_tx_wr_en = 1'b0;
    logic [DW-1:0] dev_tx_wdata = '0;
    logic          gs_select = 1'b0, gs_write_enable = 1'b0;
    logic [7:0]    gs_out;
    logic          gs_out_enable;
    logic [7:0]    rx_full_pages, tx_full_pages;
    logic          err_overflow, err_underflow;

    xfer_page_queue #(.DATA_WIDTH(DW), .PAGE_WORDS(PWORDS), .NUM_PAGES(NPAGES)) dut (
        .clock_host      (clk),
        .reset           (reset),
        .host_select     (host_select),
        .hwrite_enable   (hwrite_enable),
        .host_wdata      (host_wdata),
        .host_rdata      (host_rdata),
        .host_rvalid     (host_rvalid),
        .dev_rx_rd_en    (dev_rx_rd_en),
        .dev_rx_rdata    (dev_rx_rdata),
        .dev_rx_rvalid   (dev_rx_rvalid),
        .dev_tx_wr_en    (dev_tx_wr_en),
        .dev_tx_wdata    (dev_tx_wdata),
        .gs_select       (gs_select),
        .gs_write_enable (gs_write_enable),
        .gs_out          (gs_out),
        .gs_out_enable   (gs_out_enable),
        .rx_full_pages   (rx_full_pages),
        .tx_full_pages   (tx_full_pages),
        .err_overflow    (err_overflow),
        .err_underflow   (err_underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int rx_cnt, rx_w, rx_r, tx_cnt, tx_w, tx_r;
    bit exp_ovf, exp_udf;
    logic [7:0] exp_gs;
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] tx_q[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        rx_cnt = 0; rx_w = 0; rx_r = 0;
        tx_cnt = 0; tx_w = 0; tx_r = 0;
        exp_ovf = 0; exp_udf = 0; exp_gs = 8'd0;
        rx_q.delete();
        tx_q.delete();
    endtask

    // One clock of stimulus; the model is advanced from the pre-edge state, then outputs are checked.
    task automatic step(input bit hs, input bit hw, input logic [DW-1:0] hwd,
                        input bit rxrd, input bit txwr, input logic [DW-1:0] txd,
                        input bit gss, input bit gsw);
        bit rx_wa, rx_ra, tx_wa, tx_ra, rx_c, rx_f, tx_c, tx_f;
        logic [DW-1:0] exp_rx, exp_tx;
        host_select = hs; hwrite_enable = hw; host_wdata = hwd;
        dev_rx_rd_en = rxrd; dev_tx_wr_en = txwr; dev_tx_wdata = txd;
        gs_select = gss; gs_write_enable = gsw;

        rx_wa = hs && hw && (rx_cnt < NPAGES);
        rx_ra = rxrd && (rx_cnt > 0);
        tx_wa = txwr && (tx_cnt < NPAGES);
        tx_ra = hs && !hw && (tx_cnt > 0);
        if ((hs && hw && !rx_wa) || (txwr && !tx_wa)) exp_ovf = 1;
        if ((rxrd && !rx_ra) || (hs && !hw && !tx_ra)) exp_udf = 1;
        if (gss) exp_gs = gsw ? 8'(NPAGES - rx_cnt) : 8'(tx_cnt);

        rx_c = 0; rx_f = 0; tx_c = 0; tx_f = 0;
        exp_rx = '0; exp_tx = '0;
        if (rx_wa) begin
            rx_q.push_back(hwd);
            if (rx_w == PWORDS - 1) begin rx_w = 0; rx_c = 1; end else rx_w++;
        end
        if (rx_ra) begin
            if (rx_q.size() > 0) exp_rx = rx_q.pop_front();
            if (rx_r == PWORDS - 1) begin rx_r = 0; rx_f = 1; end else rx_r++;
        end
        if (tx_wa) begin
            tx_q.push_back(txd);
            if (tx_w == PWORDS - 1) begin tx_w = 0; tx_c = 1; end else tx_w++;
        end
        if (tx_ra) begin
            if (tx_q.size() > 0) exp_tx = tx_q.pop_front();
            if (tx_r == PWORDS - 1) begin tx_r = 0; tx_f = 1; end else tx_r++;
        end
        if (rx_c && !rx_f) rx_cnt++; else if (rx_f && !rx_c) rx_cnt--;
        if (tx_c && !tx_f) tx_cnt++; else if (tx_f && !tx_c) tx_cnt--;

        @(posedge clk); #1;
        chk("dev_rx_rvalid", {31'd0, dev_rx_rvalid}, {31'd0, rx_ra});
        if (rx_ra) chk("dev_rx_rdata", dev_rx_rdata, exp_rx);
        chk("host_rvalid", {31'd0, host_rvalid}, {31'd0, tx_ra});
        if (tx_ra) chk("host_rdata", host_rdata, exp_tx);
        chk("gs_out_enable", {31'd0, gs_out_enable}, {31'd0, gss});
        chk("gs_out", {24'd0, gs_out}, {24'd0, exp_gs});
        chk("rx_full_pages", {24'd0, rx_full_pages}, DW'(rx_cnt));
        chk("tx_full_pages", {24'd0, tx_full_pages}, DW'(tx_cnt));
        chk("err_overflow", {31'd0, err_overflow}, {31'd0, exp_ovf});
        chk("err_underflow", {31'd0, err_underflow}, {31'd0, exp_udf});
    endtask

    // Reset is applied with every access request active to show it wins.
    task automatic do_reset();
        reset = 1'b1;
        host_select = 1; hwrite_enable = 1; host_wdata = 32'hdead;
        dev_rx_rd_en = 1; dev_tx_wr_en = 1; dev_tx_wdata = 32'hbeef;
        gs_select = 1; gs_write_enable = 1;
        @(posedge clk); #1;
        reset = 1'b0;
        host_select = 0; hwrite_enable = 0; dev_rx_rd_en = 0; dev_tx_wr_en = 0; gs_select = 0;
        model_clear();
        chk("rst_rx_full", {24'd0, rx_full_pages}, 32'd0);
        chk("rst_tx_full", {24'd0, tx_full_pages}, 32'd0);
        chk("rst_flags", {27'd0, host_rvalid, dev_rx_rvalid, gs_out_enable, err_overflow, err_underflow}, 32'd0);
        chk("rst_host_rdata", host_rdata, 32'd0);
        chk("rst_dev_rx_rdata", dev_rx_rdata, 32'd0);
        chk("rst_gs_out", {24'd0, gs_out}, 32'd0);
    endtask

    task automatic rx_wr(input logic [DW-1:0] d); step(1, 1, d, 0, 0, '0, 0, 0); endtask
    task automatic rx_rd();                        step(0, 0, '0, 1, 0, '0, 0, 0); endtask
    task automatic tx_wr(input logic [DW-1:0] d); step(0, 0, '0, 0, 1, d, 0, 0); endtask
    task automatic tx_rd();                        step(1, 0, '0, 0, 0, '0, 0, 0); endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        @(posedge clk); #1;
        do_reset();

        // Single page round trip, latency-1 reads
        for (int i = 1; i <= 4; i++) rx_wr(DW'(i));
        for (int i = 0; i < 4; i++) rx_rd();

        // Status after one commit, then TX status, then hold
        for (int i = 0; i < 4; i++) rx_wr(DW'(32'h10 + i));
        step(0, 0, '0, 0, 0, '0, 1, 1);
        step(0, 0, '0, 0, 0, '0, 1, 0);
        step(0, 0, '0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) rx_rd();

        // Host read with TX empty
        tx_rd();

        // TX round trip, and a partial TX page stays invisible to the host
        for (int i = 0; i < 4; i++) tx_wr(DW'(32'hA0 + i));
        for (int i = 0; i < 2; i++) tx_wr(DW'(32'hB0 + i));
        for (int i = 0; i < 5; i++) tx_rd();

        // Fill to capacity, drop the 13th word, then drain in order
        do_reset();
        for (int i = 1; i <= 12; i++) rx_wr(DW'(i));
        rx_wr(32'd99);
        for (int i = 0; i < 12; i++) rx_rd();

        // Coinciding commit and release over more pages than the ring holds
        do_reset();
        for (int i = 0; i < 4; i++) rx_wr(DW'(100 + i));
        for (int it = 0; it < 5; it++)
            for (int k = 0; k < 4; k++)
                step(1, 1, DW'(200 + it * 4 + k), 1, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) rx_rd();

        // Reset mid-page discards the partial words
        do_reset();
        rx_wr(32'h55); rx_wr(32'h66);
        do_reset();
        for (int i = 0; i < 4; i++) rx_wr(DW'(32'h70 + i));
        for (int i = 0; i < 4; i++) rx_rd();

        // Random mixed traffic in both directions
        do_reset();
        for (int i = 0; i < 400; i++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom,
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom,
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
